burst_line_adapter: RTL
=======================

# burst_line_adapter

Initiator side of the burst-memory interface: converts one cache-line read or write request from the last-level cache into a 4-beat, 64-bit burst transaction on the DRAM-model port. Sits between the cache's memory-facing port (ufp) and the burst memory (bmem). It holds the bmem request, address and write data exactly as the memory side requires, and returns a single-cycle line response upstream.

## Interface
- LINE_WIDTH, 256: cache-line width in bits.
- BUS_WIDTH, 64: bmem data-bus width in bits. BURST_LEN = LINE_WIDTH/BUS_WIDTH (localparam, 4).
- ADDR_WIDTH, 32: byte-address width. OFFSET_W = $clog2(LINE_WIDTH/8) (localparam, 5).
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ufp_addr  in  ADDR_WIDTH  line address; low OFFSET_W bits ignored.
- ufp_read  in  1  line-read request level; held until ufp_resp.
- ufp_write  in  1  line-write request level; held until ufp_resp.
- ufp_wdata  in  LINE_WIDTH  write line; beat i = bits [i*BUS_WIDTH +: BUS_WIDTH].
- ufp_rdata  out  LINE_WIDTH  read line; valid when ufp_resp=1.
- ufp_resp  out  1  one-cycle completion pulse.
- bmem_addr  out  ADDR_WIDTH  {latched ufp_addr[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'0}.
- bmem_read  out  1  burst read request.
- bmem_write  out  1  burst write request.
- bmem_wdata  out  BUS_WIDTH  current write beat.
- bmem_rdata  in  BUS_WIDTH  read beat, valid when bmem_resp=1.
- bmem_resp  in  1  beat strobe from memory.

## Operation
- States: IDLE, RD, WR, DONE. Registers: state, addr_q, line_q (LINE_WIDTH), beat_cnt ($clog2(BURST_LEN) bits).
- IDLE: at an edge with ufp_read=1, latch addr and go to RD. With ufp_write=1 (and ufp_read=0), latch addr and ufp_wdata into line_q and go to WR. If both are 1, the read wins. beat_cnt <= 0.
- RD: bmem_read=1. At each edge with bmem_resp=1, line_q[beat_cnt*BUS_WIDTH +: BUS_WIDTH] <= bmem_rdata and beat_cnt++. On the edge of beat BURST_LEN-1, go to DONE.
- WR: bmem_write=1 and bmem_wdata = line_q slice [beat_cnt]. Each edge with bmem_resp=1 counts as one beat consumed: beat_cnt++. The last beat goes to DONE.
- DONE: ufp_resp=1 and ufp_rdata=line_q. bmem_read=bmem_write=0. Go to IDLE unconditionally.
- bmem_addr, bmem_read and bmem_write are decoded from registered state and addr_q only. They are glitch-free and stable for the whole burst; no combinational path exists from ufp_* to bmem_*.
- bmem_resp in IDLE or DONE is ignored. beat_cnt wraps naturally; the last-beat test is beat_cnt==BURST_LEN-1.
- Upstream requests that change mid-transaction are ignored: addr and wdata are latched.

## Timing
- Reset values: ufp_resp=0, ufp_rdata=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, state=IDLE, beat_cnt=0.
- rst asserted mid-burst: state returns to IDLE on that edge and all outputs go to reset values the next cycle. No partial ufp_resp is produced.
- Request-to-bmem: the request is sampled at edge e0, and bmem_read/bmem_write is high from the cycle after e0.
- Response: the last bmem_resp beat is at edge eN; ufp_resp is high in cycle eN→eN+1 only. Adapter overhead is 2 cycles plus the memory latency.
- Back-to-back: bmem_read/bmem_write is low for at least one full cycle (DONE) between bursts. This prevents the memory from re-triggering on a held request.
- Upstream must drop its request at the edge that ends DONE. A still-high request is accepted as new in IDLE at the following edge.

## Configuration
- BURST_LINE_ADAPTER_WBUF_EN defined: posted writes are enabled.
  - A write accepted in IDLE pulses ufp_resp in the next cycle. The line then drains in WR in the background.
  - A read to the same line as the buffered write (addr match) during the drain is returned from line_q 1 cycle after acceptance, without a bmem access.
  - Any other read, or a second write, is held off (no ufp_resp) until the drain completes and the state returns to IDLE.
- BURST_LINE_ADAPTER_WBUF_EN undefined: write ufp_resp only after the final beat, as in Operation.

## Structure
- Package burst_line_adapter_pkg contains:
  - state enum (IDLE, RD, WR, DONE);
  - LINE_WIDTH/BUS_WIDTH/BURST_LEN/OFFSET_W constants;
  - line_t and beat_t typedefs.
- No sub-module needed. The beat slice mux/demux is an indexed part-select in the top module.

## Test plan
- Read line 0x0000_1040 with memory beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> bmem_addr=0x0000_1040, bmem_read held for all 4 beats, ufp_rdata={0x44..,0x33..,0x22..,0x11..}, one ufp_resp pulse.
- Write line 0x0000_2000 with data {D3,D2,D1,D0} -> memory stores D0..D3 at 0x2000..0x2018 in order, bmem_write drops the cycle after the 4th beat, no memory error flag.
- ufp_addr=0x0000_301F -> bmem_addr=0x0000_3000.
- Read of 0x100 immediately followed by write of 0x100 with data 0xAA.. (request held continuously) -> DONE gap with bmem_read=bmem_write=0 for ≥1 cycle; read returns old data; subsequent read returns 0xAA...
- rst asserted after beat 2 of a read -> all outputs 0 next cycle; a fresh read after reset completes correctly.
- WBUF_EN: write 0x400 then read 0x400 during drain -> write ufp_resp 1 cycle after accept, read returns written data with no bmem_read asserted.

Source files
------------

// File: rtl/burst_line_adapter_pkg.sv
// burst_line_adapter_pkg: shared constants, types and helpers for the
// cache-line to 4-beat burst adapter.
//   LINE_WIDTH / BUS_WIDTH / ADDR_WIDTH  : bus geometry
//   BURST_LEN, OFFSET_W, CNT_W           : derived burst / offset widths
//   state_e                              : adapter FSM states
//   line_t / beat_t / addr_t             : data typedefs
//   line_base()                          : clears the in-line byte offset
package burst_line_adapter_pkg;
  localparam int LINE_WIDTH = 256;
  localparam int BUS_WIDTH  = 64;
  localparam int ADDR_WIDTH = 32;
  localparam int BURST_LEN  = LINE_WIDTH / BUS_WIDTH;
  localparam int OFFSET_W   = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W      = $clog2(BURST_LEN);

  typedef logic [LINE_WIDTH-1:0] line_t;
  typedef logic [BUS_WIDTH-1:0]  beat_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  function automatic addr_t line_base(addr_t a);
    return {a[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/burst_line_adapter_if.sv
// burst_line_adapter_if: bundles the upstream line port (ufp_*) and the
// downstream burst-memory port (bmem_*).
//   master : adapter view (consumes ufp requests, drives bmem requests)
//   slave  : environment view (cache side + burst memory)
interface burst_line_adapter_if;
  import burst_line_adapter_pkg::*;

  addr_t ufp_addr;
  logic  ufp_read;
  logic  ufp_write;
  line_t ufp_wdata;
  line_t ufp_rdata;
  logic  ufp_resp;

  addr_t bmem_addr;
  logic  bmem_read;
  logic  bmem_write;
  beat_t bmem_wdata;
  beat_t bmem_rdata;
  logic  bmem_resp;

  modport master (
    input  ufp_addr, ufp_read, ufp_write, ufp_wdata,
    output ufp_rdata, ufp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_rdata, bmem_resp
  );

  modport slave (
    output ufp_addr, ufp_read, ufp_write, ufp_wdata,
    input  ufp_rdata, ufp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_rdata, bmem_resp
  );
endinterface

// File: rtl/burst_line_adapter.sv
// burst_line_adapter: turns one cache-line read/write from the LLC into a
// BURST_LEN-beat burst on the burst-memory port and returns a one-cycle
// line response upstream.
// Ports:
//   clk  : system clock, posedge
//   rst  : synchronous active-high reset
//   bus  : burst_line_adapter_if.master (ufp_* upstream, bmem_* downstream)
// Config macro BURST_LINE_ADAPTER_WBUF_EN: posted writes. A write is
// acknowledged the cycle after acceptance and drains in the background;
// a read of the same line during the drain is served from the line buffer.
module burst_line_adapter
  import burst_line_adapter_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  burst_line_adapter_if.master bus
);

  state_e           state_q, state_d;
  addr_t            addr_q, addr_d;
  line_t            line_q, line_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             posted_q, posted_d;  // current WR already acknowledged
  logic             ack_q, ack_d;        // early response pulse pending
  logic             last_beat;
  logic             resp;

  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      line_q     <= '0;
      beat_cnt_q <= '0;
      posted_q   <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      beat_cnt_q <= beat_cnt_d;
      posted_q   <= posted_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state / datapath
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    beat_cnt_d = beat_cnt_q;
    posted_d   = posted_q;
    ack_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        beat_cnt_d = '0;
        posted_d   = 1'b0;
        if (bus.ufp_read) begin
          state_d = RD;
          addr_d  = line_base(bus.ufp_addr);
        end else if (bus.ufp_write) begin
          state_d = WR;
          addr_d  = line_base(bus.ufp_addr);
          line_d  = bus.ufp_wdata;
`ifdef BURST_LINE_ADAPTER_WBUF_EN
          posted_d = 1'b1;
          ack_d    = 1'b1;
`endif
        end
      end
      RD: begin
        if (bus.bmem_resp) begin
          line_d[beat_cnt_q*BUS_WIDTH +: BUS_WIDTH] = bus.bmem_rdata;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WR: begin
        if (bus.bmem_resp) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
`ifdef BURST_LINE_ADAPTER_WBUF_EN
        // Same-line read hits the draining buffer. Skipped while an ack is
        // still on the wire, since upstream holds its old request until then.
        if (posted_q && !ack_q && bus.ufp_read &&
            (line_base(bus.ufp_addr) == addr_q))
          ack_d = 1'b1;
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: decoded from registered state only, so bmem_* never sees ufp_*
  always_comb begin
    bus.bmem_addr  = '0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_wdata = '0;
    resp           = ack_q;
    unique case (state_q)
      RD: begin
        bus.bmem_read = 1'b1;
        bus.bmem_addr = addr_q;
      end
      WR: begin
        bus.bmem_write = 1'b1;
        bus.bmem_addr  = addr_q;
        bus.bmem_wdata = line_q[beat_cnt_q*BUS_WIDTH +: BUS_WIDTH];
      end
      DONE: if (!posted_q) resp = 1'b1;
      default: ;
    endcase
    bus.ufp_resp  = resp;
    bus.ufp_rdata = resp ? line_q : '0;
  end

endmodule
